// File: rtl/cute_lock_key_sequencer.sv
// rtl/cute_lock_key_sequencer.sv - windowed key source for a counter-locked FSM
// Stores NUM_KEYS keys, then drives key[cnt/WINDOW] on the falling-edge domain.
module cute_lock_key_sequencer #(
    parameter int KEY_W    = 16,
    parameter int NUM_KEYS = 5,
    parameter int WINDOW   = 3,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [KEY_W-1:0] load_data,
    output logic             load_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic [2:0]       win_idx,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    localparam int PERIOD = NUM_KEYS * WINDOW;
    localparam int WPTR_W = $clog2(NUM_KEYS + 1);

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WPTR_W-1:0] wptr_q, wptr_d;
    logic              err_q, err_d;
    logic [KEY_W-1:0]  key_q [NUM_KEYS];
    logic [KEY_W-1:0]  key_d [NUM_KEYS];
    logic [CNT_W-1:0]  win_full;
    logic              accept;

    assign load_ready = (state_q != RUN);
    assign key_valid  = (state_q == RUN);
    assign accept     = load_valid && load_ready;
    assign win_full   = cnt_q / CNT_W'(WINDOW);
    assign win_idx    = win_full[2:0];
    assign cnt        = cnt_q;
    assign err        = err_q;

    always_comb begin
        // The counter ignores clear and state so it never drifts from the locked FSM.
        cnt_d   = (cnt_q >= CNT_W'(PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);
        state_d = state_q;
        wptr_d  = wptr_q;
        err_d   = err_q;
        key_d   = key_q;
        if (clear) begin
            state_d = EMPTY;
            wptr_d  = '0;
            err_d   = 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_d[i] = '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (wptr_q == WPTR_W'(i)) begin
                    key_d[i] = load_data;
                end
            end
            wptr_d  = wptr_q + WPTR_W'(1);
            state_d = (wptr_q == WPTR_W'(NUM_KEYS - 1)) ? RUN : LOAD;
        end else if (load_valid) begin
            err_d = 1'b1;
        end
    end

    // Outside RUN the key is forced to zero so every window fails.
    always_comb begin
        key_out = '0;
        if (state_q == RUN) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (win_full == CNT_W'(i)) begin
                    key_out = key_q[i];
                end
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            wptr_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            err_q   <= err_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_q[i] <= key_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cute_lock_key_sequencer.sv
// tb/tb_cute_lock_key_sequencer.sv - self-checking bench for cute_lock_key_sequencer
module tb_cute_lock_key_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_ready;
    logic [15:0] key_out;
    logic        key_valid;
    logic [2:0]  win_idx;
    logic [4:0]  cnt;
    logic        err;

    cute_lock_key_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .win_idx    (win_idx),
        .cnt        (cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  cnt;
        logic [15:0] key_out;
        logic        key_valid;
        logic        load_ready;
        logic        err;
        logic [2:0]  win_idx;
    } exp_t;

    typedef struct packed {
        logic        lv;
        logic [15:0] ld;
        logic        clr;
        exp_t        e;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    vec_t vecs[20];

    int          m_cnt;
    logic [15:0] m_keys[5];
    int          m_wptr;
    logic        m_err;
    logic        m_run;

    function automatic vec_t mk(input logic lv, input logic [15:0] ld, input logic [4:0] c,
                                input logic [15:0] ko, input logic kv, input logic lr,
                                input logic [2:0] wi);
        vec_t v;
        v.lv = lv; v.ld = ld; v.clr = 1'b0;
        v.e  = '{cnt: c, key_out: ko, key_valid: kv, load_ready: lr, err: 1'b0, win_idx: wi};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wptr = 0; m_err = 1'b0; m_run = 1'b0;
        for (int i = 0; i < 5; i++) m_keys[i] = '0;
    endtask

    task automatic model_update(input logic lv, input logic [15:0] ld, input logic clr);
        if (clr) begin
            m_wptr = 0; m_err = 1'b0; m_run = 1'b0;
            for (int i = 0; i < 5; i++) m_keys[i] = '0;
        end else if (lv && !m_run) begin
            m_keys[m_wptr] = ld;
            m_wptr++;
            if (m_wptr == 5) m_run = 1'b1;
        end else if (lv) begin
            m_err = 1'b1;
        end
        m_cnt = (m_cnt + 1) % 15;
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.cnt        = 5'(m_cnt);
        e.win_idx    = 3'(m_cnt / 3);
        e.key_valid  = m_run;
        e.load_ready = !m_run;
        e.err        = m_err;
        e.key_out    = m_run ? m_keys[m_cnt / 3] : 16'h0;
        return e;
    endfunction

    task automatic step(input logic lv, input logic [15:0] ld, input logic clr, input exp_t e);
        exp_t got;
        exp_q.push_back(e);
        load_valid = lv; load_data = ld; clear = clr;
        @(negedge clk);
        @(posedge clk);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            check("cnt",        32'(cnt),        32'(got.cnt));
            check("win_idx",    32'(win_idx),    32'(got.win_idx));
            check("key_out",    32'(key_out),    32'(got.key_out));
            check("key_valid",  32'(key_valid),  32'(got.key_valid));
            check("load_ready", 32'(load_ready), 32'(got.load_ready));
            check("err",        32'(err),        32'(got.err));
        end
        load_valid = 1'b0; load_data = '0; clear = 1'b0;
    endtask

    task automatic mstep(input logic lv, input logic [15:0] ld, input logic clr);
        model_update(lv, ld, clr);
        step(lv, ld, clr, model_exp());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cnt"},        32'(cnt),        32'd0);
        check({tag, "_win_idx"},    32'(win_idx),    32'd0);
        check({tag, "_key_out"},    32'(key_out),    32'd0);
        check({tag, "_key_valid"},  32'(key_valid),  32'd0);
        check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
        check({tag, "_err"},        32'(err),        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] k[5];
        int          guard;
        k[0] = 16'hB90E; k[1] = 16'hD5D3; k[2] = 16'hFA18; k[3] = 16'h0BBD; k[4] = 16'hEFE6;

        vecs[0]  = mk(1'b1, k[0], 5'd1,  16'h0000, 1'b0, 1'b1, 3'd0);
        vecs[1]  = mk(1'b1, k[1], 5'd2,  16'h0000, 1'b0, 1'b1, 3'd0);
        vecs[2]  = mk(1'b1, k[2], 5'd3,  16'h0000, 1'b0, 1'b1, 3'd1);
        vecs[3]  = mk(1'b1, k[3], 5'd4,  16'h0000, 1'b0, 1'b1, 3'd1);
        vecs[4]  = mk(1'b1, k[4], 5'd5,  16'hD5D3, 1'b1, 1'b0, 3'd1);
        vecs[5]  = mk(1'b0, 16'h0, 5'd6,  16'hFA18, 1'b1, 1'b0, 3'd2);
        vecs[6]  = mk(1'b0, 16'h0, 5'd7,  16'hFA18, 1'b1, 1'b0, 3'd2);
        vecs[7]  = mk(1'b0, 16'h0, 5'd8,  16'hFA18, 1'b1, 1'b0, 3'd2);
        vecs[8]  = mk(1'b0, 16'h0, 5'd9,  16'h0BBD, 1'b1, 1'b0, 3'd3);
        vecs[9]  = mk(1'b0, 16'h0, 5'd10, 16'h0BBD, 1'b1, 1'b0, 3'd3);
        vecs[10] = mk(1'b0, 16'h0, 5'd11, 16'h0BBD, 1'b1, 1'b0, 3'd3);
        vecs[11] = mk(1'b0, 16'h0, 5'd12, 16'hEFE6, 1'b1, 1'b0, 3'd4);
        vecs[12] = mk(1'b0, 16'h0, 5'd13, 16'hEFE6, 1'b1, 1'b0, 3'd4);
        vecs[13] = mk(1'b0, 16'h0, 5'd14, 16'hEFE6, 1'b1, 1'b0, 3'd4);
        vecs[14] = mk(1'b0, 16'h0, 5'd0,  16'hB90E, 1'b1, 1'b0, 3'd0);
        vecs[15] = mk(1'b0, 16'h0, 5'd1,  16'hB90E, 1'b1, 1'b0, 3'd0);
        vecs[16] = mk(1'b0, 16'h0, 5'd2,  16'hB90E, 1'b1, 1'b0, 3'd0);
        vecs[17] = mk(1'b0, 16'h0, 5'd3,  16'hD5D3, 1'b1, 1'b0, 3'd1);
        vecs[18] = mk(1'b0, 16'h0, 5'd4,  16'hD5D3, 1'b1, 1'b0, 3'd1);
        vecs[19] = mk(1'b0, 16'h0, 5'd5,  16'hD5D3, 1'b1, 1'b0, 3'd1);

        model_reset();
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back load, then one full counter period plus wrap.
        for (int i = 0; i < 20; i++) begin
            model_update(vecs[i].lv, vecs[i].ld, vecs[i].clr);
            step(vecs[i].lv, vecs[i].ld, vecs[i].clr, vecs[i].e);
        end

        // Write attempt in RUN: error flag, word dropped, sequence unchanged.
        mstep(1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < 6; i++) mstep(1'b0, 16'h0, 1'b0);

        // Clear at cnt=7 together with load_valid.
        guard = 0;
        while (m_cnt != 7 && guard < 20) begin
            mstep(1'b0, 16'h0, 1'b0);
            guard++;
        end
        check("align_cnt7", 32'(cnt), 32'd7);
        mstep(1'b1, 16'hAAAA, 1'b1);
        for (int i = 0; i < 3; i++) mstep(1'b0, 16'h0, 1'b0);

        // Reload with random idle gaps between words.
        for (int w = 0; w < 5; w++) begin
            repeat ($urandom_range(0, 3)) mstep(1'b0, 16'h0, 1'b0);
            mstep(1'b1, k[w], 1'b0);
        end
        for (int i = 0; i < 16; i++) mstep(1'b0, 16'h0, 1'b0);

        // Asynchronous reset after three words, then a fresh full load.
        model_update(1'b1, 16'h0, 1'b1);
        step(1'b1, 16'h0, 1'b1, model_exp());
        for (int w = 0; w < 3; w++) mstep(1'b1, 16'($urandom), 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("midload_rst");
        #1 rst = 1'b0;
        for (int w = 0; w < 5; w++) mstep(1'b1, 16'($urandom), 1'b0);
        for (int i = 0; i < 15; i++) mstep(1'b0, 16'h0, 1'b0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
